dma_path_ctrl: RTL and testbench

Single-requester DMA path controller directly downstream of the NPU load/store controller. It grants a transfer on `dma_req`, takes the 128-bit command header and any write payload from the upstream write stream, and buffers both into a host-bound TX stream. For read commands it streams the matching number of host RX beats back upstream through a registered output stage.

---
 rtl/npu_dma_pkg.sv | 33 +++
 rtl/dma_sync_fifo.sv | 74 +++++++
 rtl/dma_path_ctrl.sv | 153 +++++++++++++++
 tb/tb_dma_path_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_dma_pkg.sv
// Shared definitions for the DMA path: header field offsets, opcodes,
// controller states and the TX FIFO entry layout.
package npu_dma_pkg;

    localparam int HDR_OP_LSB   = 72;
    localparam int HDR_LEN_LSB  = 56;
    localparam int HDR_HOST_LSB = 16;
    localparam int HDR_LOC_LSB  = 0;

    localparam logic [7:0] DMA_OP_READ  = 8'h01;
    localparam logic [7:0] DMA_OP_WRITE = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR,
        ST_RD
    } dma_state_e;

    typedef struct packed {
        logic         last;
        logic [127:0] data;
    } tx_entry_t;

    function automatic logic [7:0] hdr_op(input logic [127:0] h);
        return h[HDR_OP_LSB +: 8];
    endfunction

    function automatic logic [15:0] hdr_len(input logic [127:0] h);
        return h[HDR_LEN_LSB +: 16];
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty
// FIFO becomes visible on the head one cycle later.
module dma_sync_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    rptr_nxt;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign head_o   = head_q;
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign rptr_nxt = rptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_nxt;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Next head comes from storage, or straight from the write port
            // when the FIFO holds at most the entry being popped.
            if (do_pop) begin
                if (count_q > (AW+1)'(1)) begin
                    head_q <= mem_q[rptr_nxt];
                end else if (do_push) begin
                    head_q <= wdata_i;
                end else begin
                    head_q <= '0;
                end
            end else if (empty_o && do_push) begin
                head_q <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/dma_path_ctrl.sv
// DMA path controller: grants a transfer, forwards header/payload into the
// host TX FIFO and returns host RX beats upstream for reads.
module dma_path_ctrl
    import npu_dma_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] OP_READ    = DMA_OP_READ,
    parameter logic [7:0] OP_WRITE   = DMA_OP_WRITE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dma_req,
    output logic         dma_resp,
    input  logic         dma_write_valid,
    input  logic [127:0] dma_write_data,
    output logic         dma_write_ready,
    output logic         dma_read_valid,
    output logic [127:0] dma_read_data,
    input  logic         dma_read_ready,
    output logic         host_tx_valid,
    output logic [127:0] host_tx_data,
    output logic         host_tx_last,
    input  logic         host_tx_ready,
    input  logic         host_rx_valid,
    input  logic [127:0] host_rx_data,
    output logic         host_rx_ready,
    output logic         busy,
    output logic         err
);
    dma_state_e   state_q;
    logic [15:0]  len_q;
    logic [15:0]  cnt_q;
    logic         resp_q;
    logic         err_q;
    logic         rd_valid_q;
    logic [127:0] rd_data_q;

    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    tx_entry_t    push_entry;
    tx_entry_t    head;
    logic         wr_accept;
    logic         rx_accept;
    logic         last_beat;
    logic [7:0]   op;
    logic [15:0]  len_in;
    logic         op_ok;

    assign op        = hdr_op(dma_write_data);
    assign len_in    = hdr_len(dma_write_data);
    assign op_ok     = (op == OP_READ) || (op == OP_WRITE);
    assign last_beat = (cnt_q == len_q - 16'd1);

    assign dma_write_ready = ((state_q == ST_HDR) || (state_q == ST_WR))
                             && !fifo_full;
    assign host_rx_ready   = (state_q == ST_RD)
                             && (!rd_valid_q || dma_read_ready);
    assign wr_accept = dma_write_valid && dma_write_ready;
    assign rx_accept = host_rx_valid && host_rx_ready;

    assign fifo_push       = wr_accept && ((state_q == ST_WR) || op_ok);
    assign push_entry.data = dma_write_data;
    assign push_entry.last = (state_q == ST_WR) ? last_beat
                           : ((op == OP_READ) || (len_in == 16'd0));

    dma_sync_fifo #(
        .WIDTH ($bits(tx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (host_tx_valid && host_tx_ready),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign host_tx_valid  = !fifo_empty;
    assign host_tx_data   = head.data;
    assign host_tx_last   = head.last;
    assign dma_resp       = resp_q;
    assign err            = err_q;
    assign busy           = (state_q != ST_IDLE);
    assign dma_read_valid = rd_valid_q;
    assign dma_read_data  = rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            resp_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            resp_q <= 1'b0;
            err_q  <= 1'b0;
            // Output register drains on its own, even after RD has ended.
            if (rx_accept) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= host_rx_data;
            end else if (dma_read_ready) begin
                rd_valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (dma_req && !fifo_full) begin
                        resp_q  <= 1'b1;
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (wr_accept) begin
                        len_q <= len_in;
                        cnt_q <= '0;
                        if (!op_ok) begin
                            err_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (len_in == 16'd0) begin
                            state_q <= ST_IDLE;
                        end else if (op == OP_WRITE) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (wr_accept) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RD: begin
                    if (rx_accept) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (last_beat) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_path_ctrl.sv
// Directed/randomized bench for dma_path_ctrl with a queue-based
// reference model of the TX and read-return streams.
module tb_dma_path_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         dma_req;
    logic         dma_resp;
    logic         wv;
    logic [127:0] wd;
    logic         wr;
    logic         rv;
    logic [127:0] rdat;
    logic         rr;
    logic         tv;
    logic [127:0] td;
    logic         tl;
    logic         tr;
    logic         xv;
    logic [127:0] xd;
    logic         xr;
    logic         busy;
    logic         err;

    int vectors = 0;
    int miscompares = 0;
    int tx_seen = 0;
    int resp_cnt = 0;
    int err_cnt = 0;

    logic [128:0] exp_tx [$];
    logic [127:0] exp_rd [$];

    dma_path_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .dma_req         (dma_req),
        .dma_resp        (dma_resp),
        .dma_write_valid (wv),
        .dma_write_data  (wd),
        .dma_write_ready (wr),
        .dma_read_valid  (rv),
        .dma_read_data   (rdat),
        .dma_read_ready  (rr),
        .host_tx_valid   (tv),
        .host_tx_data    (td),
        .host_tx_last    (tl),
        .host_tx_ready   (tr),
        .host_rx_valid   (xv),
        .host_rx_data    (xd),
        .host_rx_ready   (xr),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [128:0] obs,
                       input logic [128:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] mk_hdr(input logic [7:0] op,
                                            input logic [15:0] len,
                                            input logic [39:0] host,
                                            input logic [11:0] loc);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {r[47:0], op, len, host, 4'h0, loc};
    endfunction

    // Monitors: compare every completed handshake against the model queues.
    always @(negedge clk) begin
        if (!rst && tv && tr) begin
            tx_seen++;
            chk("tx_expected_nonempty", 129'(exp_tx.size() != 0), 129'd1);
            if (exp_tx.size() != 0) chk("tx_beat", {tl, td}, exp_tx.pop_front());
        end
        if (!rst && rv && rr) begin
            chk("rd_expected_nonempty", 129'(exp_rd.size() != 0), 129'd1);
            if (exp_rd.size() != 0) chk("rd_beat", {1'b0, rdat}, {1'b0, exp_rd.pop_front()});
        end
        if (!rst && dma_resp) resp_cnt++;
        if (!rst && err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant();
        dma_req = 1'b1;
        @(negedge clk);
        chk("resp_before_edge", dma_resp, 0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("resp_pulse", dma_resp, 1);
        chk("busy_after_grant", busy, 1);
        tick();
        @(negedge clk);
        chk("resp_one_cycle", dma_resp, 0);
        tick();
    endtask

    task automatic send(input logic [127:0] d, input logic last,
                        input logic push);
        logic got;
        got = 1'b0;
        wv = 1'b1;
        wd = d;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (wr) begin
                if (push) exp_tx.push_back({last, d});
                got = 1'b1;
            end
            tick();
        end
        wv = 1'b0;
        chk("write_accept_timeout", got, 1);
    endtask

    task automatic rx_beat(input logic [127:0] d);
        logic got;
        got = 1'b0;
        xv = 1'b1;
        xd = d;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (xr) begin
                exp_rd.push_back(d);
                got = 1'b1;
            end
            tick();
        end
        xv = 1'b0;
        chk("rx_accept_timeout", got, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_tx.size() != 0 || exp_rd.size() != 0); i++)
            tick();
        chk("tx_drained", 129'(exp_tx.size()), 0);
        chk("rd_drained", 129'(exp_rd.size()), 0);
    endtask

    task automatic do_write(input logic [15:0] len, input logic [39:0] host,
                            input logic [11:0] loc);
        grant();
        send(mk_hdr(8'h03, len, host, loc), len == 16'd0, 1'b1);
        for (int i = 0; i < int'(len); i++)
            send(rnd128(), i == int'(len) - 1, 1'b1);
        @(negedge clk);
        chk("busy_after_write", busy, 0);
        tick();
    endtask

    task automatic do_read(input logic [15:0] len);
        grant();
        send(mk_hdr(8'h01, len, 40'($urandom()), 12'($urandom())), 1'b1, 1'b1);
        for (int i = 0; i < int'(len); i++) rx_beat(rnd128());
        @(negedge clk);
        chk("busy_after_read", busy, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r0, e0, k, rem;
        logic mv, exp_rdy, acc;
        logic [127:0] r0d, r1d;
        logic [127:0] rx4 [4];

        rst = 1'b1; dma_req = 1'b0; wv = 1'b0; wd = '0;
        rr = 1'b1; tr = 1'b1; xv = 1'b0; xd = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_resp", dma_resp, 0);
        chk("rst_wready", wr, 0);
        chk("rst_rvalid", rv, 0);
        chk("rst_rdata", {1'b0, rdat}, 0);
        chk("rst_txvalid", tv, 0);
        chk("rst_txlast", tl, 0);
        chk("rst_txdata", {1'b0, td}, 0);
        chk("rst_rxready", xr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_wready", wr, 0);
        tick();

        // 3-beat write
        t0 = tx_seen; r0 = resp_cnt;
        do_write(16'd3, 40'h12_3456_7890, 12'h0A0);
        drain();
        chk("wr3_tx_count", 129'(tx_seen - t0), 4);
        chk("wr3_resp_count", 129'(resp_cnt - r0), 1);

        // 2-beat read, request held across the terminal RX beat
        t0 = tx_seen; r0 = resp_cnt;
        r0d = rnd128(); r1d = rnd128();
        grant();
        send(mk_hdr(8'h01, 16'd2, 40'($urandom()), 12'h123), 1'b1, 1'b1);
        rx_beat(r0d);
        xv = 1'b1; xd = r1d; dma_req = 1'b1;
        @(negedge clk);
        chk("rd_lat_valid0", rv, 1);
        chk("rd_lat_data0", {1'b0, rdat}, {1'b0, r0d});
        chk("rd_rxready_mid", xr, 1);
        exp_rd.push_back(r1d);
        tick();
        xd = rnd128();
        @(negedge clk);
        chk("rd_lat_valid1", rv, 1);
        chk("rd_lat_data1", {1'b0, rdat}, {1'b0, r1d});
        chk("rd_third_not_ready", xr, 0);
        chk("rd_term_no_resp", dma_resp, 0);
        chk("rd_term_idle", busy, 0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("regrant_resp", dma_resp, 1);
        chk("regrant_rxready", xr, 0);
        tick();
        @(negedge clk);
        chk("regrant_resp_off", dma_resp, 0);
        chk("hdr_rxready", xr, 0);
        tick();
        xv = 1'b0;

        // zero-length write in the granted slot
        send(mk_hdr(8'h03, 16'd0, 40'($urandom()), 12'h010), 1'b1, 1'b1);
        @(negedge clk);
        chk("zlen_idle", busy, 0);
        tick();
        drain();
        chk("rd2_tx_count", 129'(tx_seen - t0), 2);
        chk("rd2_resp_count", 129'(resp_cnt - r0), 2);

        // unknown opcode
        t0 = tx_seen; e0 = err_cnt;
        grant();
        send(mk_hdr(8'h07, 16'd4, 40'($urandom()), 12'h0), 1'b0, 1'b0);
        @(negedge clk);
        chk("bad_err_pulse", err, 1);
        chk("bad_idle", busy, 0);
        tick();
        @(negedge clk);
        chk("bad_err_off", err, 0);
        tick(); tick(); tick();
        chk("bad_no_tx", 129'(tx_seen - t0), 0);
        chk("bad_err_count", 129'(err_cnt - e0), 1);

        // TX backpressure with a 20-beat write
        t0 = tx_seen;
        tr = 1'b0;
        grant();
        send(mk_hdr(8'h03, 16'd20, 40'($urandom()), 12'h200), 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) send(rnd128(), 1'b0, 1'b1);
        wv = 1'b1; wd = rnd128();
        @(negedge clk);
        chk("bp_full_wready", wr, 0);
        chk("bp_txvalid", tv, 1);
        tick();
        @(negedge clk);
        chk("bp_full_hold", wr, 0);
        tick();
        tr = 1'b1;
        send(wd, 1'b0, 1'b1);
        for (int i = 16; i < 20; i++) send(rnd128(), i == 19, 1'b1);
        @(negedge clk);
        chk("bp_idle", busy, 0);
        tick();
        drain();
        chk("bp_tx_count", 129'(tx_seen - t0), 21);

        // read with dma_read_ready toggling
        for (int i = 0; i < 4; i++) rx4[i] = rnd128();
        grant();
        send(mk_hdr(8'h01, 16'd4, 40'($urandom()), 12'h300), 1'b1, 1'b1);
        rem = 4; k = 0; mv = 1'b0;
        xv = 1'b1; xd = rx4[0];
        for (int c = 0; c < 60 && (rem > 0 || mv); c++) begin
            rr = c[0];
            @(negedge clk);
            exp_rdy = (rem > 0) && (!mv || rr);
            chk("rdbp_rxready_rule", xr, exp_rdy);
            chk("rdbp_rvalid", rv, mv);
            acc = xv && exp_rdy;
            tick();
            if (acc) begin
                exp_rd.push_back(rx4[k]);
                k++; rem--; mv = 1'b1;
                xv = (k < 4);
                xd = (k < 4) ? rx4[k % 4] : rnd128();
            end else if (mv && rr) begin
                mv = 1'b0;
            end
        end
        xv = 1'b0; rr = 1'b1;
        drain();
        chk("rdbp_beats", 129'(k), 4);

        // reset in the middle of a write
        tr = 1'b0;
        grant();
        send(mk_hdr(8'h03, 16'd5, 40'($urandom()), 12'h400), 1'b0, 1'b1);
        send(rnd128(), 1'b0, 1'b1);
        send(rnd128(), 1'b0, 1'b1);
        rst = 1'b1;
        exp_tx.delete();
        exp_rd.delete();
        tick();
        @(negedge clk);
        chk("mrst_txvalid", tv, 0);
        chk("mrst_txlast", tl, 0);
        chk("mrst_txdata", {1'b0, td}, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_wready", wr, 0);
        chk("mrst_rvalid", rv, 0);
        chk("mrst_rxready", xr, 0);
        chk("mrst_resp", dma_resp, 0);
        chk("mrst_err", err, 0);
        tick();
        rst = 1'b0;
        tr = 1'b1;
        tick();
        t0 = tx_seen;
        do_write(16'd1, 40'($urandom()), 12'h500);
        drain();
        chk("mrst_new_write", 129'(tx_seen - t0), 2);

        // random mix of transactions
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(16'($urandom_range(0, 5)), 40'($urandom()), 12'($urandom()));
            else
                do_read(16'($urandom_range(0, 5)));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
